// File: rtl/joint_step_coordinator_if.sv
// Move handshake between the arm controller and the two-axis step coordinator.
interface joint_step_coordinator_if #(
    parameter int STEP_WIDTH = 16
);
    logic                  data_ready;
    logic [STEP_WIDTH-1:0] steps1;
    logic [STEP_WIDTH-1:0] steps2;
    logic                  dir1_in;
    logic                  dir2_in;
    logic                  steppers_ready;
    logic                  move_done;

    modport master (
        output data_ready, steps1, steps2, dir1_in, dir2_in,
        input  steppers_ready, move_done
    );

    modport slave (
        input  data_ready, steps1, steps2, dir1_in, dir2_in,
        output steppers_ready, move_done
    );
endinterface

// File: rtl/joint_step_coordinator.sv
// Two-axis coordinated stepper: latches a move and spreads minor-axis steps over
// major-axis ticks (Bresenham) so both joints start and finish together.
//   state   | meaning
//   IDLE    | ready for a move, steppers_ready high
//   SETUP   | dir pins settling before the first pulse
//   TICK_HI | step pulse(s) high
//   TICK_LO | remainder of the tick period, enable checked at its end
//   DONE    | one-cycle move_done
module joint_step_coordinator #(
    parameter int STEP_WIDTH = 16,
    parameter int TICK_DIV   = 25000,
    parameter int PULSE_HIGH = 250,
    parameter int DIR_SETUP  = 50
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    joint_step_coordinator_if.slave   ctrl_if,
    output logic                      step1_o,
    output logic                      step2_o,
    output logic                      dir1_o,
    output logic                      dir2_o
);
    localparam int TMAX = (TICK_DIV > DIR_SETUP) ? TICK_DIV : DIR_SETUP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SW   = STEP_WIDTH;

    typedef enum logic [2:0] {IDLE, SETUP, TICK_HI, TICK_LO, DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] ticks_q, ticks_d;
    logic [SW-1:0] major_q, major_d;
    logic [SW-1:0] minor_q, minor_d;
    logic [SW:0]   acc_q, acc_d;
    logic          j1_major_q, j1_major_d;
    logic          dir1_q, dir1_d;
    logic          dir2_q, dir2_d;
    logic          pulse1_q, pulse1_d;
    logic          pulse2_q, pulse2_d;

    logic          tc;
    logic          start_tick;
    logic [SW:0]   acc_sum;
    logic          minor_hit;
    logic          s1_ge_s2;

    assign tc        = (timer_q == '0);
    assign acc_sum   = acc_q + {1'b0, minor_q};
    assign minor_hit = (acc_sum >= {1'b0, major_q});
    assign s1_ge_s2  = (ctrl_if.steps1 >= ctrl_if.steps2);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ticks_d    = ticks_q;
        major_d    = major_q;
        minor_d    = minor_q;
        acc_d      = acc_q;
        j1_major_d = j1_major_q;
        dir1_d     = dir1_q;
        dir2_d     = dir2_q;
        pulse1_d   = pulse1_q;
        pulse2_d   = pulse2_q;
        start_tick = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctrl_if.data_ready) begin
                    state_d    = SETUP;
                    dir1_d     = ctrl_if.dir1_in;
                    dir2_d     = ctrl_if.dir2_in;
                    j1_major_d = s1_ge_s2;
                    major_d    = s1_ge_s2 ? ctrl_if.steps1 : ctrl_if.steps2;
                    minor_d    = s1_ge_s2 ? ctrl_if.steps2 : ctrl_if.steps1;
                    acc_d      = {1'b0, major_d} >> 1;
                    ticks_d    = major_d;
                    timer_d    = TW'(DIR_SETUP - 1);
                end
            end
            SETUP: begin
                if (!tc) begin
                    timer_d = timer_q - TW'(1);
                end else if (major_q == '0) begin
                    state_d = DONE;
                end else if (enable_i) begin
                    start_tick = 1'b1;
                end
            end
            TICK_HI: begin
                if (!tc) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d  = TICK_LO;
                    timer_d  = TW'(TICK_DIV - PULSE_HIGH - 1);
                    pulse1_d = 1'b0;
                    pulse2_d = 1'b0;
                end
            end
            TICK_LO: begin
                if (!tc) begin
                    timer_d = timer_q - TW'(1);
                end else if (ticks_q == '0) begin
                    state_d = DONE;
                end else if (enable_i) begin
                    start_tick = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Major axis always steps; minor axis steps when the error term wraps.
        if (start_tick) begin
            state_d  = TICK_HI;
            timer_d  = TW'(PULSE_HIGH - 1);
            ticks_d  = ticks_q - SW'(1);
            acc_d    = minor_hit ? (acc_sum - {1'b0, major_q}) : acc_sum;
            pulse1_d = j1_major_q ? 1'b1 : minor_hit;
            pulse2_d = j1_major_q ? minor_hit : 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            ticks_q    <= '0;
            major_q    <= '0;
            minor_q    <= '0;
            acc_q      <= '0;
            j1_major_q <= 1'b0;
            dir1_q     <= 1'b0;
            dir2_q     <= 1'b0;
            pulse1_q   <= 1'b0;
            pulse2_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ticks_q    <= ticks_d;
            major_q    <= major_d;
            minor_q    <= minor_d;
            acc_q      <= acc_d;
            j1_major_q <= j1_major_d;
            dir1_q     <= dir1_d;
            dir2_q     <= dir2_d;
            pulse1_q   <= pulse1_d;
            pulse2_q   <= pulse2_d;
        end
    end

    assign step1_o                = pulse1_q;
    assign step2_o                = pulse2_q;
    assign dir1_o                 = dir1_q;
    assign dir2_o                 = dir2_q;
    assign ctrl_if.steppers_ready = (state_q == IDLE);
    assign ctrl_if.move_done      = (state_q == DONE);
endmodule
